// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants: NOP encoding, PC step, fetch FSM states.
// Latency: none (types/constants only).
// Backpressure: none (types/constants only).
package pipeline_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [31:0] PC_STEP  = 32'd4;

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_DRAIN
  } fetch_state_e;

  // One buffered fetch result: request PC plus returned instruction word.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with clear; DEPTH must be a power of two.
// Latency: a pushed word is readable at pop_data the cycle after the push.
// Backpressure: pop on empty is ignored; push on full is ignored unless a pop frees the slot.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr];

  // Pointer and occupancy tracking; clear wins over any push/pop in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_cycle.sv
// RV32I fetch stage: owns the PC, issues in-order imem requests, buffers words for decode.
// Latency: gnt in cycle N, word buffered at end of N+1, presented to decode after the N+2 edge.
// Backpressure: stall freezes the decode register; requests limited by FIFO+outstanding credit.
// Build option FETCH_MISALIGN_CHK_EN: flags misaligned redirect targets on o_fetch_misalign.
module fetch_cycle
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        i_fetch_clk,
  input  logic        i_fetch_reset_n,
  input  logic        i_fetch_stall,
  input  logic        i_fetch_flush,
  input  logic [31:0] i_fetch_redirect_pc,
  output logic        o_fetch_imem_req,
  output logic [31:0] o_fetch_imem_addr,
  input  logic        i_fetch_imem_gnt,
  input  logic        i_fetch_imem_rvalid,
  input  logic [31:0] i_fetch_imem_rdata,
  output logic [31:0] o_fetch_pc_de,
  output logic [31:0] o_fetch_inst_de,
  output logic        o_fetch_insn_vld_de,
  output logic        o_fetch_misalign
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;                      // holds 0..FIFO_DEPTH
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  fetch_state_e state, state_nxt;

  logic [31:0]   pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] out_nxt;
  logic [CW-1:0] drop;
  logic [CW-1:0] drop_nxt;
  logic [CW:0]   credit_used;

  logic          accept;
  logic          rsp_keep;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_empty;
  logic          fifo_full;
  logic [CW-1:0] fifo_count;
  fetch_entry_t  fifo_wdata;
  fetch_entry_t  fifo_rdata;

  // Request-PC queue, one entry per outstanding request that will be kept.
  logic [31:0]   pcq [FIFO_DEPTH];
  logic [AW-1:0] pcq_wr;
  logic [AW-1:0] pcq_rd;

  assign accept   = o_fetch_imem_req & i_fetch_imem_gnt;
  assign rsp_keep = i_fetch_imem_rvalid & (drop == '0) & ~i_fetch_flush;
  assign fifo_pop = ~i_fetch_flush & ~i_fetch_stall & ~fifo_empty;
  assign out_nxt  = outstanding + CW'(accept) - CW'(i_fetch_imem_rvalid);

  // The slot being popped this cycle counts as free, so a 1-cycle memory
  // sustains one instruction per cycle with only two buffer entries.
  assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding} - (CW+1)'(fifo_pop);

  assign o_fetch_imem_req  = (state == S_RUN) & ~i_fetch_flush & (credit_used < DEPTH_C);
  assign o_fetch_imem_addr = pc;

  // Next state and drop counter; a flush reloads drop with what is still in flight.
  always_comb begin
    state_nxt = state;
    drop_nxt  = drop;
    case (state)
      S_BOOT:  state_nxt = S_RUN;
      S_RUN:   state_nxt = S_RUN;
      S_DRAIN: state_nxt = S_DRAIN;
      default: state_nxt = S_BOOT;
    endcase
    if (i_fetch_flush) begin
      drop_nxt  = out_nxt;
      state_nxt = (out_nxt != '0) ? S_DRAIN : S_RUN;
    end else begin
      if (i_fetch_imem_rvalid && (drop != '0)) drop_nxt = drop - CW'(1);
      if ((state == S_DRAIN) && (drop_nxt == '0)) state_nxt = S_RUN;
    end
  end

  // FSM state, program counter and in-flight bookkeeping.
  always_ff @(posedge i_fetch_clk or negedge i_fetch_reset_n) begin
    if (!i_fetch_reset_n) begin
      state       <= S_BOOT;
      pc          <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      state       <= state_nxt;
      outstanding <= out_nxt;
      drop        <= drop_nxt;
      if (i_fetch_flush)  pc <= i_fetch_redirect_pc & ~32'h3;
      else if (accept)    pc <= pc + PC_STEP;
    end
  end

  // Request-PC queue pointers; a flush empties it since every older response is dropped.
  always_ff @(posedge i_fetch_clk or negedge i_fetch_reset_n) begin
    if (!i_fetch_reset_n) begin
      pcq_wr <= '0;
      pcq_rd <= '0;
    end else if (i_fetch_flush) begin
      pcq_wr <= '0;
      pcq_rd <= '0;
    end else begin
      if (accept)   pcq_wr <= pcq_wr + AW'(1);
      if (rsp_keep) pcq_rd <= pcq_rd + AW'(1);
    end
  end

  // Request-PC storage, written as the request is granted.
  always_ff @(posedge i_fetch_clk) begin
    if (accept) pcq[pcq_wr] <= pc;
  end

  assign fifo_wdata = '{pc: pcq[pcq_rd], inst: i_fetch_imem_rdata};
  assign fifo_push  = rsp_keep & (~fifo_full | fifo_pop);

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk       (i_fetch_clk),
    .rst_n     (i_fetch_reset_n),
    .clear     (i_fetch_flush),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // Decode-facing register: flush kills, stall holds, otherwise load head or a NOP bubble.
  always_ff @(posedge i_fetch_clk or negedge i_fetch_reset_n) begin
    if (!i_fetch_reset_n) begin
      o_fetch_pc_de       <= 32'h0;
      o_fetch_inst_de     <= NOP_INST;
      o_fetch_insn_vld_de <= 1'b0;
    end else if (i_fetch_flush) begin
      o_fetch_inst_de     <= NOP_INST;
      o_fetch_insn_vld_de <= 1'b0;
    end else if (!i_fetch_stall) begin
      if (!fifo_empty) begin
        o_fetch_pc_de       <= fifo_rdata.pc;
        o_fetch_inst_de     <= fifo_rdata.inst;
        o_fetch_insn_vld_de <= 1'b1;
      end else begin
        o_fetch_inst_de     <= NOP_INST;
        o_fetch_insn_vld_de <= 1'b0;
      end
    end
  end

`ifdef FETCH_MISALIGN_CHK_EN
  logic misalign_q;

  // Sticky misaligned-target flag, re-evaluated on every flush.
  always_ff @(posedge i_fetch_clk or negedge i_fetch_reset_n) begin
    if (!i_fetch_reset_n)   misalign_q <= 1'b0;
    else if (i_fetch_flush) misalign_q <= |i_fetch_redirect_pc[1:0];
  end

  assign o_fetch_misalign = misalign_q;
`else
  assign o_fetch_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_cycle.sv
// Scoreboard bench for fetch_cycle with an in-order imem model (variable latency/grant delay).
// Inputs driven after the falling edge, outputs sampled 1ns after the rising edge.
// Build option FETCH_MISALIGN_CHK_EN changes the expected misalign flag.
module tb_fetch_cycle;
  import pipeline_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;
`ifdef FETCH_MISALIGN_CHK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] rpc = 32'h0;
  logic        req;
  logic [31:0] addr;
  logic        gnt = 1'b0;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = 32'h0;
  logic [31:0] pc_de;
  logic [31:0] inst_de;
  logic        vld_de;
  logic        misalign;

  always #5 clk = ~clk;

  fetch_cycle #(
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .i_fetch_clk         (clk),
    .i_fetch_reset_n     (rst_n),
    .i_fetch_stall       (stall),
    .i_fetch_flush       (flush),
    .i_fetch_redirect_pc (rpc),
    .o_fetch_imem_req    (req),
    .o_fetch_imem_addr   (addr),
    .i_fetch_imem_gnt    (gnt),
    .i_fetch_imem_rvalid (rvalid),
    .i_fetch_imem_rdata  (rdata),
    .o_fetch_pc_de       (pc_de),
    .o_fetch_inst_de     (inst_de),
    .o_fetch_insn_vld_de (vld_de),
    .o_fetch_misalign    (misalign)
  );

  typedef struct {
    logic [31:0] a;
    int          due;
    bit          stale;
  } rsp_t;

  rsp_t        rsp_q[$];     // memory responses in flight
  logic [31:0] exp_q[$];     // scoreboard: PCs decode must see, in order
  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          lat = 1;
  int          gnt_delay = 0;
  int          req_age = 0;
  int          first_req = -1;
  int          first_vld = -1;
  logic [31:0] exp_pc = RESET_PC;
  logic [31:0] last_pc = 32'h0;
  logic [31:0] last_inst = NOP_INST;
  logic        last_vld = 1'b0;
  logic        exp_mis = 1'b0;
  logic        prev_wait = 1'b0;
  logic        prev_st = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (step %0d)", tag, act, exp, cyc);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; gnt = 1'b0; rvalid = 1'b0;
    #1;
    check("rst_pc_de",    pc_de,          32'h0);
    check("rst_inst_de",  inst_de,        NOP_INST);
    check("rst_vld_de",   32'(vld_de),    32'h0);
    check("rst_req",      32'(req),       32'h0);
    check("rst_addr",     addr,           RESET_PC);
    check("rst_misalign", 32'(misalign),  32'h0);
    rsp_q.delete(); exp_q.delete();
    exp_pc = RESET_PC; exp_mis = 1'b0;
    last_pc = 32'h0; last_inst = NOP_INST; last_vld = 1'b0;
    req_age = 0; prev_wait = 1'b0; prev_st = 1'b0;
    first_req = -1; first_vld = -1;
    @(posedge clk); #2;
    rst_n = 1'b1;
    cyc = 0;
  endtask

  // One clock cycle: drive inputs, run the memory model, then check the decode register.
  task automatic step(input logic st, input logic fl, input logic [31:0] r);
    logic        stale_before;
    logic        acc;
    logic [31:0] e;
    @(negedge clk);
    stall = st; flush = fl; rpc = r;
    stale_before = 1'b0;
    foreach (rsp_q[i]) if (rsp_q[i].stale) stale_before = 1'b1;
    if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
      rvalid = 1'b1;
      rdata  = mem_word(rsp_q[0].a);
      void'(rsp_q.pop_front());
    end else begin
      rvalid = 1'b0;
      rdata  = 32'hDEAD_BEEF;
    end
    #1;
    if (cyc == 0)             check("boot_noreq",  32'(req), 32'h0);
    if (fl || stale_before)   check("no_req",      32'(req), 32'h0);
    if (prev_wait && !fl && !st && !prev_st) check("req_hold", 32'(req), 32'h1);
    if (req) begin
      check("req_addr", addr, exp_pc);
      if (first_req < 0) first_req = cyc;
      gnt = (req_age >= gnt_delay);
    end else begin
      gnt = 1'b0;
    end
    acc       = req && gnt;
    prev_wait = req && !gnt;
    prev_st   = st;
    req_age   = prev_wait ? req_age + 1 : 0;
    if (acc) begin
      rsp_q.push_back(rsp_t'{a: addr, due: cyc + lat, stale: 1'b0});
      exp_q.push_back(addr);
      exp_pc = addr + 32'd4;
    end
    if (fl) begin
      foreach (rsp_q[i]) rsp_q[i].stale = 1'b1;
      exp_q.delete();
      exp_pc  = r & ~32'h3;
      exp_mis = MIS_EN && (r[1:0] != 2'b00);
    end
    @(posedge clk); #1;
    if (fl) begin
      check("flush_vld",  32'(vld_de), 32'h0);
      check("flush_inst", inst_de,     NOP_INST);
      last_vld = 1'b0; last_inst = NOP_INST;
    end else if (st) begin
      check("hold_pc",   pc_de,       last_pc);
      check("hold_inst", inst_de,     last_inst);
      check("hold_vld",  32'(vld_de), 32'(last_vld));
    end else if (vld_de) begin
      if (first_vld < 0) first_vld = cyc;
      if (exp_q.size() == 0) begin
        check("extra_vld", 32'(vld_de), 32'h0);
      end else begin
        e = exp_q.pop_front();
        check("out_pc",   pc_de,   e);
        check("out_inst", inst_de, mem_word(e));
        last_pc = e; last_inst = mem_word(e); last_vld = 1'b1;
      end
    end else begin
      check("idle_inst", inst_de, NOP_INST);
      check("idle_pc",   pc_de,   last_pc);
      last_vld = 1'b0; last_inst = NOP_INST;
    end
    check("misalign", 32'(misalign), 32'(exp_mis));
    cyc++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got %0d checks expected completion", n_chk);
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    do_reset();

    // Stream from reset with a 1-cycle memory
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 32'h0);
      if (i >= 3 && i <= 8) check("stream_vld", 32'(vld_de), 32'h1);
    end
    check("first_req_step", 32'(first_req), 32'd1);
    check("first_vld_step", 32'(first_vld), 32'd3);

    // Stall held three cycles mid-stream
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    check("stall_noreq", 32'(req), 32'h0);
    step(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0);

    // Flush with two responses outstanding
    lat = 3;
    for (int i = 0; i < 12 && rsp_q.size() < 2; i++) step(1'b0, 1'b0, 32'h0);
    check("fill_outstanding", 32'(rsp_q.size()), 32'd2);
    step(1'b0, 1'b1, 32'h0000_0100);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0);
    lat = 1;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0);

    // Flush and stall in the same cycle
    step(1'b1, 1'b1, 32'h0000_0300);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0);

    // Grant delayed four cycles
    gnt_delay = 4;
    for (int i = 0; i < 14; i++) step(1'b0, 1'b0, 32'h0);
    gnt_delay = 0;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0);

    // Misaligned redirect, then aligned redirect
    step(1'b0, 1'b1, 32'h0000_0102);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h0000_0200);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0);

    // Reset mid-stream, then restart
    step(1'b0, 1'b1, 32'h0000_0102);
    step(1'b0, 1'b0, 32'h0);
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0);

    // Stop granting and let everything in flight reach decode
    gnt_delay = 100000;
    for (int i = 0; i < 20 && (exp_q.size() > 0 || rsp_q.size() > 0); i++)
      step(1'b0, 1'b0, 32'h0);
    check("final_drain", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
